// File: rtl/dcu_trace_pkg.sv
// Shared kind encodings, record layout helpers and counter helpers for the
// DCU transaction tracer.
package dcu_trace_pkg;

    typedef enum logic [1:0] {
        KIND_LD  = 2'b00,
        KIND_ST  = 2'b01,
        KIND_LDD = 2'b10,
        KIND_RSV = 2'b11
    } kind_t;

    localparam int CHW  = 3;
    localparam int KW   = 2;
    localparam int FMAX = 64;
    localparam int RMAX = 3 * FMAX + CHW + KW;

    // Record is {ts, chan, kind, addr, data}; offsets counted from bit 0.
    function automatic int off_addr(input int dw);
        return dw;
    endfunction

    function automatic int off_kind(input int aw, input int dw);
        return aw + dw;
    endfunction

    function automatic int off_chan(input int aw, input int dw);
        return aw + dw + KW;
    endfunction

    function automatic int off_ts(input int aw, input int dw);
        return aw + dw + KW + CHW;
    endfunction

    function automatic logic [RMAX-1:0] rec_pack(
        input logic [FMAX-1:0] ts,
        input logic [CHW-1:0]  ch,
        input kind_t           kd,
        input logic [FMAX-1:0] addr,
        input logic [FMAX-1:0] data,
        input int              aw,
        input int              dw
    );
        logic [RMAX-1:0] r;
        r = RMAX'(data);
        r = r | (RMAX'(addr) << off_addr(dw));
        r = r | (RMAX'(kd) << off_kind(aw, dw));
        r = r | (RMAX'(ch) << off_chan(aw, dw));
        r = r | (RMAX'(ts) << off_ts(aw, dw));
        return r;
    endfunction

    function automatic logic [31:0] sat32(input logic [31:0] c, input logic [4:0] inc);
        logic [32:0] s;
        s = {1'b0, c} + {28'd0, inc};
        return s[32] ? '1 : s[31:0];
    endfunction

    function automatic logic [15:0] sat16(input logic [15:0] c, input logic [4:0] inc);
        logic [16:0] s;
        s = {1'b0, c} + {12'd0, inc};
        return s[16] ? '1 : s[15:0];
    endfunction

endpackage

// File: rtl/dcu_trace_fifo.sv
// Synchronous trace FIFO; head word reads as zero while empty so the
// record port is clean after reset and after the last pop.
module dcu_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign count   = cnt;
    assign dout    = empty ? '0 : mem[rp];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push_ok) wp <= wp + PW'(1);
            if (pop_ok)  rp <= rp + PW'(1);
            if (push_ok && !pop_ok)      cnt <= cnt + CW'(1);
            else if (pop_ok && !push_ok) cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/dcu_trace_mon.sv
// DCU transaction tracer: timestamps requests/returns into a trace FIFO.
// Optional DCU_TRACE_DISPLAY_EN adds simulation-only push/drop printing.
module dcu_trace_mon
    import dcu_trace_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int DEPTH   = 16,
    parameter int MAX_OUT = 4,
    parameter int TSW     = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NCH-1:0]                req_vld,
    input  logic [NCH-1:0]                req_st,
    input  logic [NCH*AW-1:0]             req_addr,
    input  logic [NCH*DW-1:0]             req_wdata,
    input  logic [NCH-1:0]                rsp_vld,
    input  logic [DW-1:0]                 rsp_data,
    input  logic                          trc_pop,
    output logic                          trc_vld,
    output logic [TSW+CHW+KW+AW+DW-1:0]   trc_rec,
    output logic [$clog2(DEPTH):0]        trc_count,
    output logic [31:0]                   ld_cnt,
    output logic [31:0]                   st_cnt,
    output logic [31:0]                   rsp_cnt,
    output logic [15:0]                   drop_cnt,
    output logic [2:0]                    err
);

    localparam int RW = TSW + CHW + KW + AW + DW;
    localparam int OW = 4;
    localparam int EW = 5;

    logic [TSW-1:0]          ts;
    logic [NCH-1:0][OW-1:0]  outstanding;
    logic [NCH-1:0][OW-1:0]  out_nxt;
    logic [NCH-1:0]          ld_ev;
    logic [NCH-1:0]          st_ev;
    logic [EW-1:0]           n_ld;
    logic [EW-1:0]           n_st;
    logic [EW-1:0]           n_rsp;
    logic [EW-1:0]           drop_inc;
    logic [2:0]              err_set;
    logic                    sel_vld;
    logic [CHW-1:0]          sel_ch;
    kind_t                   sel_kind;
    logic [AW-1:0]           sel_addr;
    logic [DW-1:0]           sel_data;
    logic [RW-1:0]           rec;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop_ok;
    logic                    push;

    assign ld_ev = req_vld & ~req_st;
    assign st_ev = req_vld & req_st;
    assign n_ld  = EW'($countones(ld_ev));
    assign n_st  = EW'($countones(st_ev));
    assign n_rsp = EW'($countones(rsp_vld));

    // Descending scans so the lowest index wins; responses beat requests.
    always_comb begin
        sel_vld  = 1'b0;
        sel_ch   = '0;
        sel_kind = KIND_LD;
        sel_addr = '0;
        sel_data = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req_vld[i]) begin
                sel_vld  = 1'b1;
                sel_ch   = CHW'(i);
                sel_kind = req_st[i] ? KIND_ST : KIND_LD;
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_st[i] ? req_wdata[i*DW +: DW] : '0;
            end
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rsp_vld[i]) begin
                sel_vld  = 1'b1;
                sel_ch   = CHW'(i);
                sel_kind = KIND_LDD;
                sel_addr = '0;
                sel_data = rsp_data;
            end
        end
    end

    assign pop_ok   = trc_pop & ~fifo_empty;
    assign push     = sel_vld & (~fifo_full | pop_ok);
    assign drop_inc = n_ld + n_st + n_rsp - EW'(sel_vld)
                    + EW'(sel_vld & fifo_full & ~pop_ok);
    assign rec      = RW'(rec_pack(FMAX'(ts), sel_ch, sel_kind,
                                   FMAX'(sel_addr), FMAX'(sel_data), AW, DW));
    assign trc_vld  = ~fifo_empty;

    always_comb begin
        out_nxt    = outstanding;
        err_set    = 3'b000;
        err_set[2] = (n_rsp > EW'(1));
        for (int i = 0; i < NCH; i++) begin
            if (ld_ev[i] && !rsp_vld[i]) begin
                if (outstanding[i] == OW'(MAX_OUT)) err_set[1] = 1'b1;
                else out_nxt[i] = outstanding[i] + OW'(1);
            end else if (rsp_vld[i] && !ld_ev[i]) begin
                if (outstanding[i] == '0) err_set[0] = 1'b1;
                else out_nxt[i] = outstanding[i] - OW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts          <= '0;
            outstanding <= '0;
            ld_cnt      <= '0;
            st_cnt      <= '0;
            rsp_cnt     <= '0;
            drop_cnt    <= '0;
            err         <= '0;
        end else begin
            ts          <= ts + TSW'(1);
            outstanding <= out_nxt;
            ld_cnt      <= sat32(ld_cnt, n_ld);
            st_cnt      <= sat32(st_cnt, n_st);
            rsp_cnt     <= sat32(rsp_cnt, n_rsp);
            drop_cnt    <= sat16(drop_cnt, drop_inc);
            err         <= err | err_set;
        end
    end

    dcu_trace_fifo #(
        .DEPTH (DEPTH),
        .W     (RW)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push),
        .din   (rec),
        .pop   (pop_ok),
        .dout  (trc_rec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (trc_count)
    );

`ifdef DCU_TRACE_DISPLAY_EN
    always @(posedge clk) begin
        if (!reset) begin
            if (push)
                $display("trace ts=%0d ch=%0d kind=%0d addr=%0h data=%0h",
                         ts, sel_ch, sel_kind, sel_addr, sel_data);
            if (sel_vld && !push)
                $display("trace drop ch=%0d reason=full", sel_ch);
            for (int i = 0; i < NCH; i++) begin
                if (rsp_vld[i] && !(sel_kind == KIND_LDD && sel_ch == CHW'(i)))
                    $display("trace drop ch=%0d reason=priority", i);
                if (req_vld[i] && !(sel_kind != KIND_LDD && sel_ch == CHW'(i)))
                    $display("trace drop ch=%0d reason=priority", i);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcu_trace_mon.sv
// Bench for dcu_trace_mon: vector table plus hand sequences, with a
// queue of expected trace records checked as the FIFO is popped.
module tb_dcu_trace_mon;

    localparam int DEPTH = 16;
    localparam int RW    = 32 + 3 + 2 + 32 + 32;

    typedef struct {
        logic [1:0]  rv;
        logic [1:0]  rs;
        logic [1:0]  pv;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] rd;
        logic        lg;
        logic [2:0]  ch;
        logic [1:0]  kd;
        int          dr;
        logic [2:0]  er;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    req_vld = '0;
    logic [1:0]    req_st = '0;
    logic [63:0]   req_addr = '0;
    logic [63:0]   req_wdata = '0;
    logic [1:0]    rsp_vld = '0;
    logic [31:0]   rsp_data = '0;
    logic          trc_pop = 1'b0;
    logic          trc_vld;
    logic [RW-1:0] trc_rec;
    logic [4:0]    trc_count;
    logic [31:0]   ld_cnt;
    logic [31:0]   st_cnt;
    logic [31:0]   rsp_cnt;
    logic [15:0]   drop_cnt;
    logic [2:0]    err;

    logic [31:0]   tcyc = '0;
    logic [RW-1:0] q[$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            exp_ld = 0;
    int            exp_st = 0;
    int            exp_rsp = 0;
    int            exp_drop = 0;
    logic [2:0]    exp_err = '0;
    vec_t          tbl[7];
    vec_t          v;

    dcu_trace_mon dut (
        .clk       (clk),
        .reset     (reset),
        .req_vld   (req_vld),
        .req_st    (req_st),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_vld   (rsp_vld),
        .rsp_data  (rsp_data),
        .trc_pop   (trc_pop),
        .trc_vld   (trc_vld),
        .trc_rec   (trc_rec),
        .trc_count (trc_count),
        .ld_cnt    (ld_cnt),
        .st_cnt    (st_cnt),
        .rsp_cnt   (rsp_cnt),
        .drop_cnt  (drop_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference timestamp: the cycle index each sampling edge will see.
    always @(posedge clk or posedge reset) begin
        if (reset) tcyc <= '0;
        else       tcyc <= tcyc + 32'd1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic vec_t mk(
        input logic [1:0] rv, rs, pv,
        input logic [31:0] a0, a1, d0, d1, rd,
        input logic lg, input logic [2:0] ch, input logic [1:0] kd,
        input int dr, input logic [2:0] er
    );
        vec_t r;
        r.rv = rv; r.rs = rs; r.pv = pv;
        r.a0 = a0; r.a1 = a1; r.d0 = d0; r.d1 = d1; r.rd = rd;
        r.lg = lg; r.ch = ch; r.kd = kd; r.dr = dr; r.er = er;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic check_state(input string nm);
        chk({nm, "_vld"}, 128'(trc_vld), 128'(q.size() != 0));
        chk({nm, "_count"}, 128'(trc_count), 128'(q.size()));
        chk({nm, "_ld"}, 128'(ld_cnt), 128'(exp_ld));
        chk({nm, "_st"}, 128'(st_cnt), 128'(exp_st));
        chk({nm, "_rsp"}, 128'(rsp_cnt), 128'(exp_rsp));
        chk({nm, "_drop"}, 128'(drop_cnt), 128'(exp_drop));
        chk({nm, "_err"}, 128'(err), 128'(exp_err));
    endtask

    // Called just after a posedge; events are sampled at the next edge.
    task automatic drive(input vec_t x, input logic pop);
        logic [31:0]   ea;
        logic [31:0]   ed;
        logic          was_full;
        logic          pop_ok;
        logic [RW-1:0] e;
        req_vld   = x.rv;
        req_st    = x.rs;
        req_addr  = {x.a1, x.a0};
        req_wdata = {x.d1, x.d0};
        rsp_vld   = x.pv;
        rsp_data  = x.rd;
        trc_pop   = pop;
        was_full  = (q.size() == DEPTH);
        pop_ok    = pop && (q.size() != 0);
        if (pop_ok) begin
            e = q.pop_front();
            chk("head_rec", 128'(trc_rec), 128'(e));
        end
        if (x.lg) begin
            case (x.kd)
                2'b00:   begin ea = x.ch[0] ? x.a1 : x.a0; ed = '0; end
                2'b01:   begin ea = x.ch[0] ? x.a1 : x.a0; ed = x.ch[0] ? x.d1 : x.d0; end
                default: begin ea = '0; ed = x.rd; end
            endcase
            if (was_full && !pop_ok) exp_drop++;
            else q.push_back({tcyc, x.ch, x.kd, ea, ed});
        end
        exp_drop += x.dr;
        exp_ld   += $countones(x.rv & ~x.rs);
        exp_st   += $countones(x.rv & x.rs);
        exp_rsp  += $countones(x.pv);
        @(posedge clk);
        #1;
        req_vld = '0;
        req_st  = '0;
        rsp_vld = '0;
        trc_pop = 1'b0;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 40 && q.size() != 0; k++) begin
            drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        end
        check_state(nm);
    endtask

    initial begin
        tbl[0] = mk(2'b10, 2'b00, 2'b00, 0, 32'h300, 0, 0, 0, 1, 1, 2'b00, 0, 3'b000);
        tbl[1] = mk(2'b01, 2'b01, 2'b10, 32'h200, 0, 32'hDEADBEEF, 0, 32'h1234,
                    1, 1, 2'b10, 1, 3'b000);
        tbl[2] = mk(2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 32'h55, 1, 0, 2'b10, 0, 3'b000);
        tbl[3] = mk(2'b11, 2'b10, 2'b00, 32'h10, 32'h20, 0, 32'h77, 0,
                    1, 0, 2'b00, 1, 3'b000);
        tbl[4] = mk(2'b01, 2'b00, 2'b01, 32'h14, 0, 0, 0, 32'h99, 1, 0, 2'b10, 1, 3'b000);
        tbl[5] = mk(2'b00, 2'b00, 2'b10, 0, 0, 0, 0, 32'hABCD, 1, 1, 2'b10, 0, 3'b001);
        tbl[6] = mk(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b001);

        repeat (3) @(posedge clk);
        #1;
        check_state("reset");
        chk("reset_rec", 128'(trc_rec), 128'(0));
        @(negedge clk);
        reset = 1'b0;

        // First load sampled at timestamp 5.
        @(posedge clk);
        #1;
        for (int k = 0; k < 20 && tcyc != 32'd5; k++) begin
            @(posedge clk);
            #1;
        end
        drive(mk(2'b01, 2'b00, 2'b00, 32'h100, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0), 1'b0);
        chk("first_rec", 128'(trc_rec), 128'({32'd5, 3'd0, 2'b00, 32'h100, 32'h0}));
        chk("first_out0", 128'(dut.outstanding[0]), 128'(1));
        check_state("first");

        for (int i = 0; i < 7; i++) begin
            v = tbl[i];
            drive(v, 1'b0);
            exp_err = v.er;
            check_state($sformatf("vec%0d", i));
        end
        for (int i = 0; i < 10; i++) begin
            idle();
            chk("err0_sticky", 128'(err), 128'(3'b001));
        end
        drain("drain1");

        // Fill past DEPTH with alternating ch0 rsp/load; 17th is dropped.
        for (int i = 0; i < 17; i++) begin
            if (i % 2 == 0)
                drive(mk(0, 0, 2'b01, 0, 0, 0, 0, 32'(i), 1, 0, 2'b10, 0, 0), 1'b0);
            else
                drive(mk(2'b01, 0, 0, 32'h1000 + i, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0), 1'b0);
        end
        check_state("full");
        drive(mk(2'b01, 0, 0, 32'h2000, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0), 1'b1);
        check_state("full_pp");
        drain("drain2");

        drive(mk(0, 0, 2'b01, 0, 0, 0, 0, 32'h66, 1, 0, 2'b10, 0, 0), 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(mk(2'b01, 0, 0, 32'h3000 + i, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0), 1'b0);
            if (i == 4) exp_err = 3'b011;
            check_state($sformatf("max%0d", i));
        end
        chk("max_out0", 128'(dut.outstanding[0]), 128'(4));
        drive(mk(2'b01, 0, 2'b01, 32'h4000, 0, 0, 0, 32'h77, 1, 0, 2'b10, 1, 0), 1'b0);
        chk("ldrsp_out0", 128'(dut.outstanding[0]), 128'(4));
        check_state("ldrsp");

        drive(mk(0, 0, 2'b11, 0, 0, 0, 0, 32'h4242, 1, 0, 2'b10, 1, 0), 1'b0);
        exp_err = 3'b111;
        check_state("multi_rsp");
        drive(mk(2'b10, 0, 0, 0, 32'h5000, 0, 0, 0, 1, 1, 2'b00, 0, 0), 1'b0);

        // Asynchronous reset while records are queued.
        #3;
        reset = 1'b1;
        #1;
        q.delete();
        exp_ld = 0; exp_st = 0; exp_rsp = 0; exp_drop = 0; exp_err = '0;
        check_state("mid_reset");
        chk("mid_reset_rec", 128'(trc_rec), 128'(0));
        chk("mid_reset_out", 128'(dut.outstanding), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        drive(mk(2'b01, 2'b01, 0, 32'h600, 0, 32'hCAFE, 0, 0, 1, 0, 2'b01, 0, 0), 1'b0);
        check_state("post_reset");
        drain("drain3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dcu_trace_mon.md
# dcu_trace_mon

Parametrised data-cache-unit transaction tracer sitting beside the DCU on the IU/SMU request and load-return paths. It timestamps every load request, store and load-data return on NCH requester channels and tracks per-channel outstanding loads. Records go into a bounded trace FIFO drained through a valid/pop handshake, with sticky protocol-error flags and saturating event counters. It replaces print-only DCU debug monitoring with a buffered, checkable trace usable in simulation and in emulation builds.

## Interface
- NCH, 2, number of requester channels (ch0 = IU, ch1 = SMU by convention); 1..8
- AW, 32, address width
- DW, 32, data width
- DEPTH, 16, trace FIFO entries; power of two, >= 2
- MAX_OUT, 4, max outstanding loads per channel; 1..15
- TSW, 32, timestamp width
- clk  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-high reset
- req_vld  in  NCH  request issued on channel i this cycle
- req_st  in  NCH  1 = store, 0 = load (qualified by req_vld[i])
- req_addr  in  NCH*AW  channel i address at bits [i*AW +: AW]
- req_wdata  in  NCH*DW  channel i store data
- rsp_vld  in  NCH  load data returned to channel i
- rsp_data  in  DW  shared load-return data
- trc_pop  in  1  consume head record (effective only when trc_vld)
- trc_vld  out  1  FIFO non-empty
- trc_rec  out  TSW+3+2+AW+DW  head record {ts, chan, kind, addr, data}; chan is 3 bits
- trc_count  out  $clog2(DEPTH)+1  entries held
- ld_cnt, st_cnt, rsp_cnt  out  32 each  saturating event counters
- drop_cnt  out  16  saturating count of events not recorded
- err  out  3  sticky: [0] rsp with zero outstanding, [1] load at MAX_OUT outstanding, [2] >1 rsp_vld bit in one cycle

## Operation
- Kind encoding: 00 load request, 01 store, 10 load data, 11 reserved (never written). Load-request records carry data = 0. Load-data records carry addr = 0.
- Timestamp: free-running TSW-bit counter incremented every cycle; wraps to 0 silently.
- Event selection: at most one record pushed per cycle. Fixed priority: lowest-index rsp_vld first, then lowest-index req_vld. Every other event that cycle increments drop_cnt by one each.
- A selected event is also dropped (drop_cnt +1) when the FIFO is full and trc_pop is not accepted the same cycle.
- ld_cnt, st_cnt and rsp_cnt count every event, including dropped ones. They saturate at all-ones.
- Outstanding counter per channel, range 0..MAX_OUT:
  - load req: +1
  - rsp: -1
  - both in the same cycle: unchanged
  - load at MAX_OUT without rsp: hold, set err[1]
  - rsp at 0 without load: hold, set err[0]; the record is still logged
- err bits and all counters clear only on reset.

## Timing
- Reset: trc_vld=0, trc_count=0, trc_rec=0, all counters 0, err=0, timestamp 0, outstanding 0.
- Event sampled at posedge N: record appears at the FIFO tail after posedge N and carries ts = timestamp value at N. If the FIFO was empty, trc_vld=1 from cycle N+1.
- Pop: trc_pop && trc_vld advances the head at posedge. Pop while empty is ignored.
- Push and pop in the same cycle while full: both accepted, count unchanged, no drop.
- Push and pop in the same cycle with count 1: head replaced, trc_vld stays 1.
- Pointers wrap modulo DEPTH.
- Reset asserted mid-operation clears the FIFO contents count and all state immediately (asynchronous).

## Configuration
- DCU_TRACE_DISPLAY_EN defined: on each accepted push, a simulation-only display prints timestamp, channel, kind, address and data. On each drop it prints channel and reason (priority or full).
- Not defined: no display code is compiled. Behaviour at the ports is identical in both cases.

## Structure
- Package dcu_trace_pkg holds:
  - kind encodings
  - chan field width (3)
  - record field offsets
  - record-pack function
- Sub-module dcu_trace_fifo: synchronous FIFO (DEPTH, width param) with push, pop, full, empty and count outputs.
- Selection logic, outstanding counters, event counters and error logic stay in the top module.

## Test plan
- Reset, then ch0 load addr 0x100 at cycle 5 -> trc_vld=1 at cycle 6, rec {ts=5, chan=0, kind=00, addr=0x100, data=0}, outstanding[0]=1.
- ch0 store 0x200/0xDEADBEEF and ch1 rsp 0x1234 in the same cycle -> rsp record logged, store dropped, drop_cnt=1, st_cnt=1, rsp_cnt=1.
- 17 single loads/responses with no pop, DEPTH=16 -> trc_count=16, drop_cnt=1. Then pop+push in one cycle -> count stays 16, no new drop.
- ch1 rsp with no outstanding load -> err[0]=1, sticky through 10 further clean cycles; the record is still logged.
- 5 ch0 loads without responses, MAX_OUT=4 -> err[1]=1, outstanding[0]=4. Load+rsp in one cycle -> outstanding unchanged.
- rsp_vld=2'b11 -> err[2]=1, ch0 record logged, drop_cnt +1. Assert reset mid-stream -> all outputs return to reset values the same cycle.
